id_ex_stage_reg: RTL and testbench
==================================

Name: id_ex_stage_reg

Overview:
- Pipeline register between decode and execute.
- Captures the decoded instruction bundle: PC, register-file operands, the already-extended 32-bit immediate, register indices, shift amount and the packed control word.
- Supports hold (stall), bubble insertion (flush) and a writeback bypass into captured and held operands. This keeps the execute stage free of stale register values across the register-file write/read collision and across multi-cycle stalls.

Parameters:
WIDTH_DATA, 32, width of PC, operands and immediate
WIDTH_REG, 5, register index width
WIDTH_CTRL, 16, width of packed control word (bit 0 = RegWrite; an all-zero word is a NOP)

Ports:
CLK  in  1  clock, rising edge
nRST  in  1  reset, asynchronous, active-low
Stall  in  1  hold current EX contents
Flush  in  1  load a bubble on next edge
IDValid  in  1  decode holds a valid instruction
IDPC  in  WIDTH_DATA  instruction PC
IDRD1  in  WIDTH_DATA  register-file read data for Rs
IDRD2  in  WIDTH_DATA  register-file read data for Rt
IDExt  in  WIDTH_DATA  extended immediate from the extender
IDRs, IDRt, IDRd  in  WIDTH_REG  register indices
IDShamt  in  5  shift amount
IDCtrl  in  WIDTH_CTRL  control word
WBWrite  in  1  writeback stage writes the register file this cycle
WBReg  in  WIDTH_REG  writeback destination
WBData  in  WIDTH_DATA  writeback data
EXValid  out  1  EX slot holds a valid instruction
EXPC, EXRD1, EXRD2, EXExt  out  WIDTH_DATA  registered copies
EXRs, EXRt, EXRd  out  WIDTH_REG  registered indices
EXShamt  out  5  registered shift amount
EXCtrl  out  WIDTH_CTRL  registered control word

Behaviour:
- All outputs are registered. Latency is 1 cycle from ID inputs to EX outputs.
- Reset: nRST low asynchronously clears every output to 0, so EXValid=0 and EXCtrl=0. Reset asserted mid-stall or mid-flush discards all state. The first edge after release loads normally.
- Per-edge priority is Flush > Stall > Load.
- Flush: EXValid, EXCtrl and all data/index outputs become 0. Flush wins over a simultaneous Stall.
- Stall (without Flush): all outputs hold, except operand refresh:
  - If WBWrite=1, WBReg!=0 and WBReg==EXRs, then EXRD1<=WBData.
  - Same rule with EXRt updates EXRD2.
  - Refresh applies even when EXValid=0; the value is harmless because EXCtrl=0.
- Load: all fields take their ID inputs. EXValid<=IDValid.
  - If IDValid=0, EXCtrl is forced to 0 and the other fields are still loaded.
  - Bypass on load: if WBWrite=1, WBReg!=0 and WBReg==IDRs, EXRD1<=WBData instead of IDRD1. Same rule with IDRt for EXRD2. Rs==Rt==WBReg updates both.
- Register 0 is never bypassed. With WBReg=0, EXRD1/EXRD2 take IDRD1/IDRD2 or hold.
- IDExt, IDPC, IDShamt and IDCtrl pass through unmodified. No arithmetic is performed here.
- Stall and Flush are level-sampled at each edge. Multi-cycle stalls hold indefinitely.

Optional Feature:
- Macro: ID_EX_STATS_EN.
- Defined: adds outputs StallCnt[15:0] and BubbleCnt[15:0], both reset to 0 by nRST.
  - StallCnt increments on every edge with Stall=1 and Flush=0.
  - BubbleCnt increments on every edge with Flush=1, or a load with IDValid=0.
  - Both saturate at 16'hFFFF; they do not wrap.
- Undefined: the ports and counters are absent. Datapath behaviour is identical.

Test Plan:
- Reset/load: nRST=0 for 2 cycles, then load IDPC=32'h00400010, IDExt=32'hFFFF8000, IDCtrl=16'h0041, IDValid=1 -> during reset all outputs 0; one edge later EXPC=32'h00400010, EXExt=32'hFFFF8000, EXCtrl=16'h0041, EXValid=1.
- Load bypass: IDRs=5'd8, IDRD1=32'h11111111, WBWrite=1, WBReg=5'd8, WBData=32'hCAFEBABE -> EXRD1=32'hCAFEBABE. Repeat with WBReg=0, IDRs=0 -> EXRD1=IDRD1.
- Stall refresh: hold Stall=1 for 3 cycles with EXRt=5'd9; in cycle 2 drive WBWrite=1, WBReg=9, WBData=32'h00000123 -> EXRD2=32'h00000123 after that edge; all other outputs unchanged for all 3 cycles.
- Flush priority: Stall=1 and Flush=1 on one edge with valid contents -> EXValid=0, EXCtrl=16'h0000, EXRD1=0.
- Async reset mid-stall: assert nRST low between edges while Stall=1 -> outputs clear immediately without a clock edge.
- With ID_EX_STATS_EN: 4 stall edges and 2 flush edges -> StallCnt=4, BubbleCnt=2. Preload StallCnt=16'hFFFF and stall once more -> stays 16'hFFFF.

Source files
------------

// File: rtl/id_ex_stage_reg_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | id_ex_stage_reg_if : decode->execute bundle, writeback bypass and stats   |
// | Rev 1.0 (StallCnt/BubbleCnt exist only with ID_EX_STATS_EN)               |
// +--------------------------------------------------------------------------+
interface id_ex_stage_reg_if #(
  parameter int WIDTH_DATA = 32,
  parameter int WIDTH_REG  = 5,
  parameter int WIDTH_CTRL = 16
);
  logic                  Stall;
  logic                  Flush;
  logic                  IDValid;
  logic [WIDTH_DATA-1:0] IDPC;
  logic [WIDTH_DATA-1:0] IDRD1;
  logic [WIDTH_DATA-1:0] IDRD2;
  logic [WIDTH_DATA-1:0] IDExt;
  logic [WIDTH_REG-1:0]  IDRs;
  logic [WIDTH_REG-1:0]  IDRt;
  logic [WIDTH_REG-1:0]  IDRd;
  logic [4:0]            IDShamt;
  logic [WIDTH_CTRL-1:0] IDCtrl;
  logic                  WBWrite;
  logic [WIDTH_REG-1:0]  WBReg;
  logic [WIDTH_DATA-1:0] WBData;

  logic                  EXValid;
  logic [WIDTH_DATA-1:0] EXPC;
  logic [WIDTH_DATA-1:0] EXRD1;
  logic [WIDTH_DATA-1:0] EXRD2;
  logic [WIDTH_DATA-1:0] EXExt;
  logic [WIDTH_REG-1:0]  EXRs;
  logic [WIDTH_REG-1:0]  EXRt;
  logic [WIDTH_REG-1:0]  EXRd;
  logic [4:0]            EXShamt;
  logic [WIDTH_CTRL-1:0] EXCtrl;
`ifdef ID_EX_STATS_EN
  logic [15:0]           StallCnt;
  logic [15:0]           BubbleCnt;
`endif

  modport master (
    output Stall, Flush, IDValid, IDPC, IDRD1, IDRD2, IDExt,
    output IDRs, IDRt, IDRd, IDShamt, IDCtrl, WBWrite, WBReg, WBData,
`ifdef ID_EX_STATS_EN
    input  StallCnt, BubbleCnt,
`endif
    input  EXValid, EXPC, EXRD1, EXRD2, EXExt, EXRs, EXRt, EXRd, EXShamt, EXCtrl
  );

  modport slave (
    input  Stall, Flush, IDValid, IDPC, IDRD1, IDRD2, IDExt,
    input  IDRs, IDRt, IDRd, IDShamt, IDCtrl, WBWrite, WBReg, WBData,
`ifdef ID_EX_STATS_EN
    output StallCnt, BubbleCnt,
`endif
    output EXValid, EXPC, EXRD1, EXRD2, EXExt, EXRs, EXRt, EXRd, EXShamt, EXCtrl
  );
endinterface
`default_nettype wire

// File: rtl/id_ex_stage_reg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | id_ex_stage_reg : ID/EX pipeline register, flush > stall > load, WB bypass|
// | Rev 1.0 (ID_EX_STATS_EN adds saturating stall/bubble counters)            |
// +--------------------------------------------------------------------------+
module id_ex_stage_reg #(
  parameter int WIDTH_DATA = 32,
  parameter int WIDTH_REG  = 5,
  parameter int WIDTH_CTRL = 16
) (
  input  wire               CLK,
  input  wire               nRST,
  id_ex_stage_reg_if.slave  bus
);

  logic                  valid_q, valid_d;
  logic [WIDTH_DATA-1:0] pc_q, pc_d;
  logic [WIDTH_DATA-1:0] rd1_q, rd1_d;
  logic [WIDTH_DATA-1:0] rd2_q, rd2_d;
  logic [WIDTH_DATA-1:0] ext_q, ext_d;
  logic [WIDTH_REG-1:0]  rs_q, rs_d;
  logic [WIDTH_REG-1:0]  rt_q, rt_d;
  logic [WIDTH_REG-1:0]  rd_q, rd_d;
  logic [4:0]            shamt_q, shamt_d;
  logic [WIDTH_CTRL-1:0] ctrl_q, ctrl_d;

  // Register 0 is hard-wired zero, so a write to it must never be forwarded.
  logic wb_live;
  logic hit_id_rs, hit_id_rt, hit_ex_rs, hit_ex_rt;

  always_comb begin
    wb_live   = bus.WBWrite && (bus.WBReg != '0);
    hit_id_rs = wb_live && (bus.WBReg == bus.IDRs);
    hit_id_rt = wb_live && (bus.WBReg == bus.IDRt);
    hit_ex_rs = wb_live && (bus.WBReg == rs_q);
    hit_ex_rt = wb_live && (bus.WBReg == rt_q);
  end

  always_comb begin
    valid_d = valid_q;
    pc_d    = pc_q;
    rd1_d   = rd1_q;
    rd2_d   = rd2_q;
    ext_d   = ext_q;
    rs_d    = rs_q;
    rt_d    = rt_q;
    rd_d    = rd_q;
    shamt_d = shamt_q;
    ctrl_d  = ctrl_q;
    if (bus.Flush) begin
      valid_d = 1'b0;
      pc_d    = '0;
      rd1_d   = '0;
      rd2_d   = '0;
      ext_d   = '0;
      rs_d    = '0;
      rt_d    = '0;
      rd_d    = '0;
      shamt_d = '0;
      ctrl_d  = '0;
    end else if (bus.Stall) begin
      // Held operands are refreshed so a long stall never leaves stale data.
      if (hit_ex_rs) rd1_d = bus.WBData;
      if (hit_ex_rt) rd2_d = bus.WBData;
    end else begin
      valid_d = bus.IDValid;
      pc_d    = bus.IDPC;
      rd1_d   = hit_id_rs ? bus.WBData : bus.IDRD1;
      rd2_d   = hit_id_rt ? bus.WBData : bus.IDRD2;
      ext_d   = bus.IDExt;
      rs_d    = bus.IDRs;
      rt_d    = bus.IDRt;
      rd_d    = bus.IDRd;
      shamt_d = bus.IDShamt;
      ctrl_d  = bus.IDValid ? bus.IDCtrl : '0;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      rd1_q   <= '0;
      rd2_q   <= '0;
      ext_q   <= '0;
      rs_q    <= '0;
      rt_q    <= '0;
      rd_q    <= '0;
      shamt_q <= '0;
      ctrl_q  <= '0;
    end else begin
      valid_q <= valid_d;
      pc_q    <= pc_d;
      rd1_q   <= rd1_d;
      rd2_q   <= rd2_d;
      ext_q   <= ext_d;
      rs_q    <= rs_d;
      rt_q    <= rt_d;
      rd_q    <= rd_d;
      shamt_q <= shamt_d;
      ctrl_q  <= ctrl_d;
    end
  end

  assign bus.EXValid = valid_q;
  assign bus.EXPC    = pc_q;
  assign bus.EXRD1   = rd1_q;
  assign bus.EXRD2   = rd2_q;
  assign bus.EXExt   = ext_q;
  assign bus.EXRs    = rs_q;
  assign bus.EXRt    = rt_q;
  assign bus.EXRd    = rd_q;
  assign bus.EXShamt = shamt_q;
  assign bus.EXCtrl  = ctrl_q;

`ifdef ID_EX_STATS_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic [15:0] bubble_cnt_q, bubble_cnt_d;

  // Counters saturate so a long run reads as "at least this many", never wraps.
  always_comb begin
    stall_cnt_d  = stall_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    if (bus.Stall && !bus.Flush && (stall_cnt_q != 16'hFFFF))
      stall_cnt_d = stall_cnt_q + 16'd1;
    if ((bus.Flush || (!bus.Stall && !bus.IDValid)) && (bubble_cnt_q != 16'hFFFF))
      bubble_cnt_d = bubble_cnt_q + 16'd1;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      stall_cnt_q  <= stall_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign bus.StallCnt  = stall_cnt_q;
  assign bus.BubbleCnt = bubble_cnt_q;
`else
  // Datapath-only build: no statistics state.
`endif

endmodule
`default_nettype wire

// File: tb/tb_id_ex_stage_reg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_id_ex_stage_reg : directed + randomized bench with a behavioural model |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module tb_id_ex_stage_reg;

  logic CLK;
  logic nRST;
  int   n_checks;
  int   n_errors;

  id_ex_stage_reg_if #(.WIDTH_DATA(32), .WIDTH_REG(5), .WIDTH_CTRL(16)) bus ();

  id_ex_stage_reg #(.WIDTH_DATA(32), .WIDTH_REG(5), .WIDTH_CTRL(16)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    bit        valid;
    bit [31:0] pc, rd1, rd2, ext;
    bit [4:0]  rs, rt, rd, shamt;
    bit [15:0] ctrl;
  } ex_t;

  ex_t m;
  int  m_stalls;
  int  m_bubbles;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    m = '{default: 0};
    m_stalls  = 0;
    m_bubbles = 0;
  endfunction

  // What the EX slot should contain after the coming edge, from the stated rules.
  function automatic void model_edge();
    bit fwd;
    fwd = bus.WBWrite && (bus.WBReg != 0);
    if (bus.Flush) begin
      m = '{default: 0};
      m_bubbles = (m_bubbles < 65535) ? m_bubbles + 1 : 65535;
    end else if (bus.Stall) begin
      if (fwd && bus.WBReg == m.rs) m.rd1 = bus.WBData;
      if (fwd && bus.WBReg == m.rt) m.rd2 = bus.WBData;
      m_stalls = (m_stalls < 65535) ? m_stalls + 1 : 65535;
    end else begin
      m.valid = bus.IDValid;
      m.pc    = bus.IDPC;
      m.rd1   = (fwd && bus.WBReg == bus.IDRs) ? bus.WBData : bus.IDRD1;
      m.rd2   = (fwd && bus.WBReg == bus.IDRt) ? bus.WBData : bus.IDRD2;
      m.ext   = bus.IDExt;
      m.rs    = bus.IDRs;
      m.rt    = bus.IDRt;
      m.rd    = bus.IDRd;
      m.shamt = bus.IDShamt;
      m.ctrl  = bus.IDValid ? bus.IDCtrl : 16'h0;
      if (!bus.IDValid) m_bubbles = (m_bubbles < 65535) ? m_bubbles + 1 : 65535;
    end
  endfunction

  task automatic compare_all(input string ph);
    chk({ph, ".valid"}, {31'd0, bus.EXValid}, {31'd0, m.valid});
    chk({ph, ".pc"},    bus.EXPC,  m.pc);
    chk({ph, ".rd1"},   bus.EXRD1, m.rd1);
    chk({ph, ".rd2"},   bus.EXRD2, m.rd2);
    chk({ph, ".ext"},   bus.EXExt, m.ext);
    chk({ph, ".rs"},    {27'd0, bus.EXRs},    {27'd0, m.rs});
    chk({ph, ".rt"},    {27'd0, bus.EXRt},    {27'd0, m.rt});
    chk({ph, ".rd"},    {27'd0, bus.EXRd},    {27'd0, m.rd});
    chk({ph, ".shamt"}, {27'd0, bus.EXShamt}, {27'd0, m.shamt});
    chk({ph, ".ctrl"},  {16'd0, bus.EXCtrl},  {16'd0, m.ctrl});
`ifdef ID_EX_STATS_EN
    chk({ph, ".stallcnt"},  {16'd0, bus.StallCnt},  m_stalls);
    chk({ph, ".bubblecnt"}, {16'd0, bus.BubbleCnt}, m_bubbles);
`endif
  endtask

  // Inputs are set at posedge+1, so they are stable across the next edge.
  task automatic step(input string ph);
    model_edge();
    @(posedge CLK);
    #1;
    compare_all(ph);
  endtask

  task automatic idle_inputs();
    bus.Stall = 0; bus.Flush = 0; bus.IDValid = 0;
    bus.IDPC = 0; bus.IDRD1 = 0; bus.IDRD2 = 0; bus.IDExt = 0;
    bus.IDRs = 0; bus.IDRt = 0; bus.IDRd = 0; bus.IDShamt = 0; bus.IDCtrl = 0;
    bus.WBWrite = 0; bus.WBReg = 0; bus.WBData = 0;
  endtask

  initial begin
    ex_t snap;
    n_checks = 0;
    n_errors = 0;
    idle_inputs();
    nRST = 1'b0;
    model_reset();

    // Reset held for two cycles
    repeat (2) @(posedge CLK);
    #1;
    compare_all("reset");

    // First load after release
    nRST = 1'b1;
    bus.IDValid = 1; bus.IDPC = 32'h00400010; bus.IDExt = 32'hFFFF8000; bus.IDCtrl = 16'h0041;
    step("load0");
    chk("load0.pc_const",    bus.EXPC, 32'h00400010);
    chk("load0.ext_const",   bus.EXExt, 32'hFFFF8000);
    chk("load0.ctrl_const",  {16'd0, bus.EXCtrl}, 32'h0041);
    chk("load0.valid_const", {31'd0, bus.EXValid}, 32'd1);

    // Load-time bypass, then register 0 never bypassed
    bus.IDRs = 5'd8; bus.IDRD1 = 32'h11111111;
    bus.WBWrite = 1; bus.WBReg = 5'd8; bus.WBData = 32'hCAFEBABE;
    step("bypass");
    chk("bypass.rd1_const", bus.EXRD1, 32'hCAFEBABE);
    bus.IDRs = 5'd0; bus.WBReg = 5'd0;
    step("bypass_r0");
    chk("bypass_r0.rd1_const", bus.EXRD1, 32'h11111111);

    // Stall refresh with EXRt=9
    bus.WBWrite = 0; bus.IDRt = 5'd9; bus.IDRD2 = 32'h55AA55AA; bus.IDRd = 5'd3;
    step("pre_stall");
    snap = m;
    bus.Stall = 1; bus.IDPC = 32'hDEAD0000; bus.IDRD2 = 32'h0; bus.IDRt = 5'd1;
    step("stall1");
    chk("stall1.rd2_hold", bus.EXRD2, 32'h55AA55AA);
    bus.WBWrite = 1; bus.WBReg = 5'd9; bus.WBData = 32'h00000123;
    step("stall2");
    chk("stall2.rd2_refresh", bus.EXRD2, 32'h00000123);
    bus.WBWrite = 0;
    step("stall3");
    chk("stall3.pc_hold", bus.EXPC, snap.pc);
    chk("stall3.rt_hold", {27'd0, bus.EXRt}, 32'd9);

    // Flush beats Stall
    bus.Flush = 1;
    step("flush");
    chk("flush.valid_const", {31'd0, bus.EXValid}, 32'd0);
    chk("flush.ctrl_const",  {16'd0, bus.EXCtrl}, 32'd0);
    chk("flush.rd1_const",   bus.EXRD1, 32'd0);
    bus.Flush = 0; bus.Stall = 0;

    // Randomized traffic, small register space so bypass hits are frequent
    for (int i = 0; i < 300; i++) begin
      bus.Stall   = ($urandom_range(0, 9) < 3);
      bus.Flush   = ($urandom_range(0, 9) == 0);
      bus.IDValid = ($urandom_range(0, 3) != 0);
      bus.IDPC    = $urandom; bus.IDRD1 = $urandom; bus.IDRD2 = $urandom;
      bus.IDExt   = $urandom;
      bus.IDRs    = 5'($urandom_range(0, 3));
      bus.IDRt    = 5'($urandom_range(0, 3));
      bus.IDRd    = 5'($urandom);
      bus.IDShamt = 5'($urandom);
      bus.IDCtrl  = 16'($urandom);
      bus.WBWrite = $urandom_range(0, 1) == 1;
      bus.WBReg   = 5'($urandom_range(0, 3));
      bus.WBData  = $urandom;
      step("rand");
    end

    // Async reset in the middle of a stall, between edges
    bus.Flush = 0; bus.Stall = 0; bus.IDValid = 1; bus.IDCtrl = 16'h00FF; bus.IDPC = 32'h1234;
    step("pre_areset");
    bus.Stall = 1;
    #2 nRST = 1'b0;
    model_reset();
    #1;
    compare_all("areset");
    chk("areset.valid_const", {31'd0, bus.EXValid}, 32'd0);
    @(posedge CLK);
    #1 nRST = 1'b1;

`ifdef ID_EX_STATS_EN
    bus.IDValid = 1;
    bus.Stall = 1;
    repeat (4) step("stat_stall");
    bus.Flush = 1;
    repeat (2) step("stat_flush");
    chk("stat.stall_const",  {16'd0, bus.StallCnt},  32'd4);
    chk("stat.bubble_const", {16'd0, bus.BubbleCnt}, 32'd2);
    bus.Flush = 0;
    for (int i = 0; i < 65531; i++) begin
      model_edge();
      @(posedge CLK);
    end
    #1;
    chk("stat.stall_full", {16'd0, bus.StallCnt}, 32'h0000FFFF);
    step("stat_sat");
    chk("stat.stall_sat", {16'd0, bus.StallCnt}, 32'h0000FFFF);
    bus.Stall = 0;
`endif

    idle_inputs();
    step("tail");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
